// File: rtl/mem_access_ctrl_if.sv
// Bus bundle between the load/store sequencer, data memory and the size-handler mux.
interface mem_access_ctrl_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] mem_rdata;
  logic [31:0] sh_out;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] rdata_q;
  logic [31:0] wdata_q;
  logic [2:0]  sh_sel;
  logic [31:0] load_data;
  logic        busy;
  logic        done;
  logic        err;

  modport slave (
    input  start, op, addr, wdata, mem_rdata, sh_out,
    output mem_addr, mem_rd, mem_wr, mem_wdata, rdata_q, wdata_q,
           sh_sel, load_data, busy, done, err
  );

  modport master (
    output start, op, addr, wdata, mem_rdata, sh_out,
    input  mem_addr, mem_rd, mem_wr, mem_wdata, rdata_q, wdata_q,
           sh_sel, load_data, busy, done, err
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// Multicycle LB/LH/LW/SB/SH/SW sequencer: alignment check, memory read with fixed
// latency, size-handler mux select, load capture and read-modify-write stores.
module mem_access_ctrl #(
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  mem_access_ctrl_if.slave  bus
);
  localparam logic [2:0] OP_LB = 3'd0, OP_LH = 3'd1, OP_LW = 3'd2,
                         OP_SB = 3'd3, OP_SH = 3'd4, OP_SW = 3'd5;
  localparam logic [2:0] SEL_SB = 3'b000, SEL_SW = 3'b001, SEL_SH = 3'b010,
                         SEL_LB = 3'b011, SEL_LW = 3'b100, SEL_LH = 3'b101,
                         SEL_REP = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE, S_READ, S_WAIT, S_LOAD, S_WRITE, S_DONE
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] load_q, load_d;
  logic        err_q, err_d;
  logic        bad_req;
  logic        rd_last;
  logic        is_load;

  always_comb begin
    case (bus.op)
      OP_LW, OP_SW: bad_req = |bus.addr[1:0];
      OP_LH, OP_SH: bad_req = bus.addr[0];
      OP_LB, OP_SB: bad_req = 1'b0;
      default:      bad_req = 1'b1;
    endcase
  end

  assign rd_last = (state_q == S_WAIT) && (cnt_q == 3'd1);
  assign is_load = (op_q == OP_LB) || (op_q == OP_LH) || (op_q == OP_LW);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_d    = bus.op;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          err_d   = bad_req;
          if (bad_req)              state_d = S_DONE;
          else if (bus.op == OP_SW) state_d = S_WRITE;
          else                      state_d = S_READ;
        end
      end
      S_READ: begin
        cnt_d   = 3'(MEM_LAT);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = is_load ? S_LOAD : S_WRITE;
      end
      S_LOAD:  state_d = S_DONE;
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes and mux select are pure functions of state so the external mux
  // never loops back into the next-state logic.
  always_comb begin
    bus.mem_rd = (state_q == S_READ);
    bus.mem_wr = (state_q == S_WRITE);
    bus.done   = (state_q == S_DONE);
    bus.sh_sel = SEL_REP;
    if (state_q == S_LOAD) begin
      case (op_q)
        OP_LB:   bus.sh_sel = SEL_LB;
        OP_LH:   bus.sh_sel = SEL_LH;
        default: bus.sh_sel = SEL_LW;
      endcase
    end else if (state_q == S_WRITE) begin
      case (op_q)
        OP_SB:   bus.sh_sel = SEL_SB;
        OP_SH:   bus.sh_sel = SEL_SH;
        default: bus.sh_sel = SEL_SW;
      endcase
    end
  end

  always_comb begin
    rdata_d = rd_last ? bus.mem_rdata : rdata_q;
    load_d  = (state_q == S_LOAD) ? bus.sh_out : load_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      load_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      load_q  <= load_d;
      err_q   <= err_d;
    end
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = bus.mem_wr ? bus.sh_out : 32'h0;
  assign bus.rdata_q   = rdata_q;
  assign bus.wdata_q   = wdata_q;
  assign bus.load_data = load_q;
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.err       = (state_q == S_DONE) && err_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench: size-handler mux, latency-L memory and a per-cycle transaction model,
// plus directed literal scenarios and a randomized phase.
module tb_mem_access_ctrl;
  localparam int L = 1;

  typedef struct {
    bit          busy, done, err, rd, wr, mupd;
    logic [2:0]  sel;
    logic [31:0] maddr, wdat, rq, wq, ld;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_access_ctrl_if bus ();
  mem_access_ctrl #(.MEM_LAT(L)) dut (.clk_i(clk), .reset_i(reset), .bus(bus));

  function automatic logic [31:0] bswap(input logic [31:0] v);
    return {v[7:0], v[15:8], v[23:16], v[31:24]};
  endfunction

  function automatic logic [31:0] shmux(input logic [2:0] s, input logic [31:0] r, input logic [31:0] b);
    case (s)
      3'b000:  return {b[7:0], r[23:0]};
      3'b001:  return bswap(b);
      3'b010:  return {b[7:0], b[15:8], r[15:0]};
      3'b011:  return {24'h0, r[7:0]};
      3'b100:  return bswap(r);
      3'b101:  return {16'h0, r[15:8], r[23:16]};
      default: return r;
    endcase
  endfunction

  assign bus.sh_out = shmux(bus.sh_sel, bus.rdata_q, bus.wdata_q);

  logic [31:0] tb_mem [64];
  logic [31:0] model_mem [64];
  logic [31:0] pipe [L];
  exp_t        q[$];
  logic [31:0] h_addr, h_rq, h_wq, h_ld;
  bit          cur_idle = 1'b1;
  int          checks = 0, errors = 0, cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d got %h want %h", nm, cyc, act, exp);
    end
  endtask

  // Expand one accepted request into its expected cycle-by-cycle output trace.
  task automatic gen(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t r;
    bit bad;
    logic [31:0] w;
    logic [2:0] sel;
    r.busy = 1; r.done = 0; r.err = 0; r.rd = 0; r.wr = 0; r.mupd = 0;
    r.sel = 3'b111; r.maddr = a; r.wdat = 0; r.rq = h_rq; r.wq = b; r.ld = h_ld;
    bad = (op > 3'd5) || ((op == 3'd2 || op == 3'd5) && a[1:0] != 2'b00) ||
          ((op == 3'd1 || op == 3'd4) && a[0]);
    if (bad) begin
      r.done = 1; r.err = 1; q.push_back(r);
      return;
    end
    if (op == 3'd5) begin
      r.wr = 1; r.sel = 3'b001; r.wdat = bswap(b); r.mupd = 1; q.push_back(r);
      r.wr = 0; r.sel = 3'b111; r.wdat = 0; r.mupd = 0; r.done = 1; q.push_back(r);
      return;
    end
    r.rd = 1; q.push_back(r); r.rd = 0;
    repeat (L) q.push_back(r);
    w = model_mem[a[7:2]];
    r.rq = w;
    case (op)
      3'd0:    sel = 3'b011;
      3'd1:    sel = 3'b101;
      3'd2:    sel = 3'b100;
      3'd3:    sel = 3'b000;
      default: sel = 3'b010;
    endcase
    r.sel = sel;
    if (op < 3'd3) begin
      q.push_back(r);
      r.ld = shmux(sel, w, b);
    end else begin
      r.wr = 1; r.wdat = shmux(sel, w, b); r.mupd = 1; q.push_back(r);
      r.wr = 0; r.wdat = 0; r.mupd = 0;
    end
    r.sel = 3'b111; r.done = 1; q.push_back(r);
  endtask

  // One clock: memory service, model update and full output comparison.
  task automatic tick();
    exp_t e;
    bit wr_now, rd_now;
    logic [5:0] mi;
    logic [31:0] wd_now;
    wr_now = (bus.mem_wr === 1'b1);
    rd_now = (bus.mem_rd === 1'b1);
    mi     = bus.mem_addr[7:2];
    wd_now = bus.mem_wdata;
    if (reset) begin
      q.delete(); h_addr = 0; h_rq = 0; h_wq = 0; h_ld = 0;
    end else if (bus.start && cur_idle) begin
      gen(bus.op, bus.addr, bus.wdata);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (wr_now) tb_mem[mi] = wd_now;
    for (int i = L - 1; i > 0; i--) pipe[i] = pipe[i-1];
    if (rd_now) pipe[0] = tb_mem[mi];
    bus.mem_rdata = pipe[L-1];
    if (q.size() > 0) begin
      e = q.pop_front();
      cur_idle = 1'b0;
    end else begin
      e.busy = 0; e.done = 0; e.err = 0; e.rd = 0; e.wr = 0; e.mupd = 0;
      e.sel = 3'b111; e.maddr = h_addr; e.wdat = 0; e.rq = h_rq; e.wq = h_wq; e.ld = h_ld;
      cur_idle = 1'b1;
    end
    h_addr = e.maddr; h_rq = e.rq; h_wq = e.wq; h_ld = e.ld;
    if (e.mupd) model_mem[e.maddr[7:2]] = e.wdat;
    chk("busy", 32'(bus.busy), 32'(e.busy));
    chk("done", 32'(bus.done), 32'(e.done));
    chk("err", 32'(bus.err), 32'(e.err));
    chk("mem_rd", 32'(bus.mem_rd), 32'(e.rd));
    chk("mem_wr", 32'(bus.mem_wr), 32'(e.wr));
    chk("sh_sel", 32'(bus.sh_sel), 32'(e.sel));
    chk("mem_addr", bus.mem_addr, e.maddr);
    chk("mem_wdata", bus.mem_wdata, e.wdat);
    chk("rdata_q", bus.rdata_q, e.rq);
    chk("wdata_q", bus.wdata_q, e.wq);
    chk("load_data", bus.load_data, e.ld);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit poke, output int dcyc, output int derr, output int nrd,
                        output int nwr, output int wcyc, output logic [31:0] wdat,
                        output logic [31:0] ld, output logic [2:0] lsel);
    int k;
    k = 0;
    while (!cur_idle && k < 20) begin tick(); k++; end
    bus.start = 1; bus.op = op; bus.addr = a; bus.wdata = b;
    tick();
    bus.start = 0;
    dcyc = -1; derr = 0; nrd = 0; nwr = 0; wcyc = -1; wdat = 0; ld = 0; lsel = 3'b111;
    for (int c = 1; c <= 20; c++) begin
      if (bus.mem_rd === 1'b1) nrd++;
      if (bus.mem_wr === 1'b1) begin nwr++; wcyc = c; wdat = bus.mem_wdata; end
      if (bus.sh_sel inside {3'b011, 3'b100, 3'b101}) lsel = bus.sh_sel;
      if (bus.done === 1'b1) begin
        dcyc = c; derr = int'(bus.err); ld = bus.load_data;
        break;
      end
      if (poke && c == 1) begin
        bus.start = 1; bus.op = 3'd0; bus.addr = 32'h0; bus.wdata = 32'h0;
      end
      tick();
      bus.start = 0;
    end
  endtask

  initial begin
    int dcyc, derr, nrd, nwr, wcyc, ndone;
    logic [31:0] wd, ld, a;
    logic [2:0] ls;
    bus.start = 0; bus.op = 0; bus.addr = 0; bus.wdata = 0; bus.mem_rdata = 0;
    for (int i = 0; i < L; i++) pipe[i] = 0;
    for (int i = 0; i < 64; i++) begin
      tb_mem[i] = $urandom; model_mem[i] = tb_mem[i];
    end
    tb_mem[16] = 32'h11223344; model_mem[16] = 32'h11223344;
    h_addr = 0; h_rq = 0; h_wq = 0; h_ld = 0;
    reset = 1;
    tick(); tick();
    reset = 0;
    chk("rst_sel", 32'(bus.sh_sel), 32'h7);
    chk("rst_load", bus.load_data, 32'h0);
    tick();

    run_op(3'd2, 32'h40, 32'h0, 0, dcyc, derr, nrd, nwr, wcyc, wd, ld, ls);
    chk("t1_done_cyc", dcyc, 4); chk("t1_err", derr, 0);
    chk("t1_ld", ld, 32'h44332211); chk("t1_sel", 32'(ls), 32'h4);
    run_op(3'd0, 32'h40, 32'h0, 0, dcyc, derr, nrd, nwr, wcyc, wd, ld, ls);
    chk("t2_lb", ld, 32'h00000044);
    run_op(3'd1, 32'h40, 32'h0, 0, dcyc, derr, nrd, nwr, wcyc, wd, ld, ls);
    chk("t2_lh", ld, 32'h00003322);
    run_op(3'd3, 32'h40, 32'hAB, 0, dcyc, derr, nrd, nwr, wcyc, wd, ld, ls);
    chk("t3_nrd", nrd, 1); chk("t3_nwr", nwr, 1);
    chk("t3_wcyc", wcyc, 3); chk("t3_wdata", wd, 32'hAB223344); chk("t3_done_cyc", dcyc, 4);
    run_op(3'd5, 32'h44, 32'hDEADBEEF, 0, dcyc, derr, nrd, nwr, wcyc, wd, ld, ls);
    chk("t4_nrd", nrd, 0); chk("t4_wcyc", wcyc, 1);
    chk("t4_wdata", wd, 32'hEFBEADDE); chk("t4_done_cyc", dcyc, 2);
    run_op(3'd2, 32'h42, 32'h0, 0, dcyc, derr, nrd, nwr, wcyc, wd, ld, ls);
    chk("t5_lw_cyc", dcyc, 1); chk("t5_lw_err", derr, 1); chk("t5_lw_strb", nrd + nwr, 0);
    run_op(3'd4, 32'h41, 32'h1234, 0, dcyc, derr, nrd, nwr, wcyc, wd, ld, ls);
    chk("t5_sh_cyc", dcyc, 1); chk("t5_sh_err", derr, 1); chk("t5_sh_strb", nrd + nwr, 0);
    run_op(3'd7, 32'h40, 32'h0, 0, dcyc, derr, nrd, nwr, wcyc, wd, ld, ls);
    chk("t5_op7_cyc", dcyc, 1); chk("t5_op7_err", derr, 1); chk("t5_op7_strb", nrd + nwr, 0);

    // Reset lands in the WAIT cycle of an SB; the write must never appear.
    tick();
    bus.start = 1; bus.op = 3'd3; bus.addr = 32'h40; bus.wdata = 32'hCD;
    tick();
    bus.start = 0;
    nwr = int'(bus.mem_wr);
    tick();
    nwr += int'(bus.mem_wr);
    reset = 1;
    tick();
    reset = 0;
    chk("t6_busy", 32'(bus.busy), 32'h0); chk("t6_sel", 32'(bus.sh_sel), 32'h7);
    chk("t6_load", bus.load_data, 32'h0); chk("t6_rdata", bus.rdata_q, 32'h0);
    for (int i = 0; i < 3; i++) begin tick(); nwr += int'(bus.mem_wr); end
    chk("t6_nwr", nwr, 0);
    run_op(3'd2, 32'h40, 32'h0, 1, dcyc, derr, nrd, nwr, wcyc, wd, ld, ls);
    chk("t6_lw_cyc", dcyc, 4); chk("t6_lw_ld", ld, 32'h443322AB);
    ndone = 0;
    for (int i = 0; i < 8; i++) begin tick(); ndone += int'(bus.done); end
    chk("t6_poke_ignored", ndone, 0);

    for (int i = 0; i < 2000; i++) begin
      a = $urandom & 32'hFC;
      if ($urandom_range(0, 3) == 0) a = a + 32'($urandom_range(0, 3));
      bus.start = ($urandom_range(0, 2) == 0);
      bus.op    = 3'($urandom_range(0, 7));
      bus.addr  = a;
      bus.wdata = $urandom;
      reset     = ($urandom_range(0, 149) == 0);
      tick();
    end
    reset = 0; bus.start = 0;
    repeat (12) tick();
    for (int i = 0; i < 64; i++) chk("mem_image", tb_mem[i], model_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
